// File: rtl/finalprojectsoc_keycode_in.sv
// Avalon-MM keycode input port: synchronises an external keycode bus, queues
// nonzero changes in a FIFO drained by CPU reads, and raises a maskable IRQ.
module finalprojectsoc_keycode_in #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [DATA_W-1:0] in_port,
   output logic              irq
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_IRQMSK = 2'd2,
      REG_LIVE   = 2'd3
   } reg_addr_e;

   logic [DATA_W-1:0] sync_pipe_q [SYNC_STAGES];
   logic [DATA_W-1:0] sync_q;
   logic [DATA_W-1:0] prev_q;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              mask_q, mask_d;
   logic              irq_q;

   logic              empty, full;
   logic              push_evt, pop_req, do_push, do_pop;
   logic              wr_strobe, ovf_clr;
   reg_addr_e         addr_e;

   logic              unused_wdata;
   assign unused_wdata = ^{writedata[31:9], writedata[7:1]};

   assign addr_e = reg_addr_e'(address);
   assign sync_q = sync_pipe_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_pipe_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_pipe_q[0] <= in_port;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_pipe_q[i] <= sync_pipe_q[i-1];
         end
         prev_q <= sync_q;
      end
   end

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign push_evt  = (sync_q != prev_q) && (sync_q != '0);
   assign pop_req   = chipselect && read && (addr_e == REG_DATA);
   assign do_pop    = pop_req && !empty;
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign do_push   = push_evt && (!full || do_pop);
   assign wr_strobe = chipselect && !write_n;
   assign ovf_clr   = wr_strobe && (addr_e == REG_STATUS) && writedata[8];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      mask_d   = mask_q;

      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end

      // Clear first so a simultaneous overflow event takes priority.
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (push_evt && full && !do_pop) begin
         ovf_d = 1'b1;
      end

      if (wr_strobe && (addr_e == REG_IRQMSK)) begin
         mask_d = writedata[0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         mask_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         mask_q   <= mask_d;
         irq_q    <= mask_q && !empty;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= sync_q;
      end
   end

   always_comb begin
      readdata = '0;
      unique case (addr_e)
         REG_DATA: begin
            if (!empty) begin
               readdata[DATA_W-1:0] = mem_q[rd_ptr_q];
            end
         end
         REG_STATUS: begin
            readdata[CW-1:0] = count_q;
            readdata[8]      = ovf_q;
            readdata[9]      = empty;
            readdata[10]     = full;
         end
         REG_IRQMSK: readdata[0] = mask_q;
         REG_LIVE:   readdata[DATA_W-1:0] = sync_q;
         default:    readdata = '0;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_finalprojectsoc_keycode_in.sv
// Directed bench for finalprojectsoc_keycode_in: latency, ordering, overflow,
// simultaneous push/pop corners and asynchronous reset.
module tb_finalprojectsoc_keycode_in;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   finalprojectsoc_keycode_in #(
      .DATA_W(8),
      .FIFO_DEPTH(8),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .read(read),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .in_port(in_port),
      .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // All tasks start and end just after a negedge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1 d = readdata;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      read       = 1'b1;
      #1 d = readdata;
      @(negedge clk);
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
      address    = a;
      writedata  = v;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [31:0] exp_v [4];
      exp_v[0] = 32'h0; exp_v[1] = 32'h200; exp_v[2] = 32'h0; exp_v[3] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         bus_read(2'(i), d);
         n_checks++;
         if (d !== exp_v[i]) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %h expected %h", i, d, exp_v[i]);
         end
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_latency();
      logic [31:0] d;
      bus_write(2'd2, 32'h1);
      in_port = 8'h1A;
      step(2);
      peek(2'd3, d);
      n_checks++;
      if (d !== 32'h1A) begin n_fail++; $display("FAIL live_edge2: got %h expected 1a", d); end
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h200) begin n_fail++; $display("FAIL count_edge2: got %h expected 200", d); end
      step(1);
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h001 || irq !== 1'b0) begin
         n_fail++; $display("FAIL count_edge3: got %h irq %b expected 001 irq 0", d, irq);
      end
      step(1);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_edge4: got %b expected 1", irq); end
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'h1A) begin n_fail++; $display("FAIL pop_1a: got %h expected 1a", d); end
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h200 || irq !== 1'b1) begin
         n_fail++; $display("FAIL after_pop: got %h irq %b expected 200 irq 1", d, irq);
      end
      step(1);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop: got %b expected 0", irq); end
      in_port = 8'h00;
      step(4);
   endtask

   task automatic test_sequence();
      logic [31:0] d;
      logic [7:0]  seq [4];
      logic [7:0]  exp_q [3];
      seq[0] = 8'h04; seq[1] = 8'h00; seq[2] = 8'h04; seq[3] = 8'h07;
      exp_q[0] = 8'h04; exp_q[1] = 8'h04; exp_q[2] = 8'h07;
      for (int i = 0; i < 4; i++) begin
         in_port = seq[i];
         step(4);
      end
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h003) begin n_fail++; $display("FAIL seq_count: got %h expected 003", d); end
      for (int i = 0; i < 3; i++) begin
         bus_read(2'd0, d);
         n_checks++;
         if (d !== {24'h0, exp_q[i]}) begin
            n_fail++; $display("FAIL seq_pop%0d: got %h expected %h", i, d, exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      for (int i = 0; i < 9; i++) begin
         in_port = 8'h11 + 8'(i);
         step(4);
      end
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h508) begin n_fail++; $display("FAIL ovf_status: got %h expected 508", d); end
      peek(2'd0, d);
      n_checks++;
      if (d !== 32'h11) begin n_fail++; $display("FAIL ovf_head: got %h expected 11", d); end
      // Clear on the same edge as another dropped push: set must win.
      in_port = 8'h1A;
      step(2);
      bus_write(2'd1, 32'h100);
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h508) begin n_fail++; $display("FAIL ovf_set_wins: got %h expected 508", d); end
      bus_write(2'd1, 32'h100);
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h408) begin n_fail++; $display("FAIL ovf_clear: got %h expected 408", d); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [7:0]  exp_q [8];
      for (int i = 0; i < 7; i++) exp_q[i] = 8'h12 + 8'(i);
      exp_q[7] = 8'h20;
      in_port = 8'h20;
      step(2);
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'h11) begin n_fail++; $display("FAIL full_pushpop_data: got %h expected 11", d); end
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h408) begin n_fail++; $display("FAIL full_pushpop_status: got %h expected 408", d); end
      for (int i = 0; i < 8; i++) begin
         bus_read(2'd0, d);
         n_checks++;
         if (d !== {24'h0, exp_q[i]}) begin
            n_fail++; $display("FAIL drain%0d: got %h expected %h", i, d, exp_q[i]);
         end
      end
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL empty_read: got %h expected 0", d); end
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h200) begin n_fail++; $display("FAIL empty_status: got %h expected 200", d); end
      // Read of an empty FIFO on the push edge: push lands, pop does nothing.
      in_port = 8'h21;
      step(2);
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL empty_pushpop_data: got %h expected 0", d); end
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h001) begin n_fail++; $display("FAIL empty_pushpop_status: got %h expected 001", d); end
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'h21) begin n_fail++; $display("FAIL empty_pushpop_pop: got %h expected 21", d); end
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      in_port = 8'h2C;
      step(4);
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h001 || irq !== 1'b1) begin
         n_fail++; $display("FAIL prereset: got %h irq %b expected 001 irq 1", d, irq);
      end
      address    = 2'd0;
      chipselect = 1'b1;
      read       = 1'b1;
      #2 reset_n = 1'b0;
      #1 address = 2'd1;
      #1;
      n_checks++;
      if (readdata !== 32'h200 || irq !== 1'b0) begin
         n_fail++; $display("FAIL in_reset: got %h irq %b expected 200 irq 0", readdata, irq);
      end
      @(negedge clk);
      chipselect = 1'b0;
      read       = 1'b0;
      reset_n    = 1'b1;
      step(2);
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h200) begin n_fail++; $display("FAIL rst_edge2: got %h expected 200", d); end
      step(1);
      peek(2'd1, d);
      n_checks++;
      if (d !== 32'h001) begin n_fail++; $display("FAIL rst_edge3: got %h expected 001", d); end
      peek(2'd0, d);
      n_checks++;
      if (d !== 32'h2C) begin n_fail++; $display("FAIL rst_requeue: got %h expected 2c", d); end
      peek(2'd2, d);
      step(1);
      n_checks++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL rst_mask: got %h irq %b expected 0 irq 0", d, irq);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      read       = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      step(3);
      reset_n = 1'b1;
      step(1);
      test_reset();
      test_latency();
      test_sequence();
      test_overflow();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
